// File: rtl/irq_priority_ctrl_pkg.sv
// Shared constants for the 8-source interrupt priority controller.
package irq_priority_ctrl_pkg;

    localparam int unsigned N_SRC = 8;
    localparam int unsigned ID_W  = 3;

    // Handshake FSM encoding
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OFFER = 1'b1;

endpackage : irq_priority_ctrl_pkg

// File: rtl/irq_priority_ctrl_prio_enc8.sv
// Combinational 8:3 priority encoder, highest set index wins; zero input gives id 0, valid 0.
module prio_enc8
    import irq_priority_ctrl_pkg::*;
(
    input  logic [N_SRC-1:0] req_i,
    output logic [ID_W-1:0]  id_o,
    output logic             valid_o
);

    // Ascending scan so the last (highest) set bit overrides lower ones
    always_comb begin
        id_o    = '0;
        valid_o = 1'b0;
        for (int i = 0; i < int'(N_SRC); i++) begin
            if (req_i[i]) begin
                id_o    = ID_W'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule : prio_enc8

// File: rtl/irq_priority_ctrl.sv
// Interrupt front-end: edge capture into pending, masking, priority select, req/ack offer.
// Optional build macro IRQ_SYNC_EN adds a 2-flop input synchronizer (latency 2 -> 4 clocks).
module irq_priority_ctrl
    import irq_priority_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] irq_in,
    input  logic [N_SRC-1:0] irq_mask,
    output logic             irq_req,
    output logic [ID_W-1:0]  irq_id,
    input  logic             irq_ack,
    output logic [N_SRC-1:0] pending
);

    logic [N_SRC-1:0] irq_s;
    logic [N_SRC-1:0] hist_q;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] edge_vec;
    logic [N_SRC-1:0] clr_vec;
    logic [N_SRC-1:0] sel;
    logic [ID_W-1:0]  enc_id;
    logic             any_sel;
    logic [0:0]       state_q, state_d;
    logic             irq_req_q, irq_req_d;
    logic [ID_W-1:0]  irq_id_q, irq_id_d;

`ifdef IRQ_SYNC_EN
    logic [N_SRC-1:0] sync1_q, sync2_q;

    // Two-stage synchronizer for asynchronous request lines
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_in;
            sync2_q <= sync1_q;
        end
    end

    assign irq_s = sync2_q;
`else
    assign irq_s = irq_in;
`endif

    // Rising-edge detect against last sampled level
    assign edge_vec = irq_s & ~hist_q;

    // Only unmasked pending sources compete for selection
    assign sel = pending_q & ~irq_mask;

    prio_enc8 u_prio_enc8 (
        .req_i   (sel),
        .id_o    (enc_id),
        .valid_o (any_sel)
    );

    // Pending update: clear serviced source on ack, new edge wins over clear
    always_comb begin
        clr_vec = '0;
        if (state_q == ST_OFFER && irq_ack) begin
            clr_vec[irq_id_q] = 1'b1;
        end
        pending_d = (pending_q & ~clr_vec) | edge_vec;
    end

    // Handshake FSM next-state and registered-output next values
    always_comb begin
        state_d   = state_q;
        irq_req_d = irq_req_q;
        irq_id_d  = irq_id_q;
        case (state_q)
            ST_IDLE: begin
                irq_req_d = 1'b0;
                if (any_sel) begin
                    state_d   = ST_OFFER;
                    irq_req_d = 1'b1;
                    irq_id_d  = enc_id;
                end
            end
            ST_OFFER: begin
                if (irq_ack) begin
                    state_d   = ST_IDLE;
                    irq_req_d = 1'b0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                irq_req_d = 1'b0;
            end
        endcase
    end

    // State, history and pending registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            irq_req_q <= 1'b0;
            irq_id_q  <= '0;
            hist_q    <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            irq_req_q <= irq_req_d;
            irq_id_q  <= irq_id_d;
            hist_q    <= irq_s;
            pending_q <= pending_d;
        end
    end

    assign irq_req = irq_req_q;
    assign irq_id  = irq_id_q;
    assign pending = pending_q;

endmodule : irq_priority_ctrl

// File: tb/tb_irq_priority_ctrl.sv
// Directed self-checking bench for irq_priority_ctrl (honours IRQ_SYNC_EN for latency).
module tb_irq_priority_ctrl;

`ifdef IRQ_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif

    logic       clk;
    logic       rst_n;
    logic [7:0] irq_in;
    logic [7:0] irq_mask;
    logic       irq_req;
    logic [2:0] irq_id;
    logic       irq_ack;
    logic [7:0] pending;

    int err_cnt = 0;
    int chk_cnt = 0;

    irq_priority_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .irq_in   (irq_in),
        .irq_mask (irq_mask),
        .irq_req  (irq_req),
        .irq_id   (irq_id),
        .irq_ack  (irq_ack),
        .pending  (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle pulse; returns once the edge has reached the pending register
    task automatic pulse(input logic [7:0] v);
        irq_in = v;
        tick();
        irq_in = 8'h00;
        repeat (SYNC) tick();
    endtask

    task automatic ack_once();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        irq_in   = 8'h00;
        irq_mask = 8'h00;
        irq_ack  = 1'b0;
        tick();
        check("rst_req", 32'(irq_req), 32'h0);
        check("rst_id", 32'(irq_id), 32'h0);
        check("rst_pend", 32'(pending), 32'h0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Single source, basic latency
        pulse(8'h04);
        check("s1_pend", 32'(pending), 32'h04);
        check("s1_req_early", 32'(irq_req), 32'h0);
        tick();
        check("s1_req", 32'(irq_req), 32'h1);
        check("s1_id", 32'(irq_id), 32'h2);
        ack_once();
        check("s1_pend_clr", 32'(pending), 32'h00);
        check("s1_req_drop", 32'(irq_req), 32'h0);

        // Two simultaneous sources, highest first, idle gap between offers
        pulse(8'h81);
        check("s2_pend", 32'(pending), 32'h81);
        tick();
        check("s2_id7", 32'(irq_id), 32'h7);
        check("s2_req7", 32'(irq_req), 32'h1);
        ack_once();
        check("s2_gap", 32'(irq_req), 32'h0);
        check("s2_pend1", 32'(pending), 32'h01);
        tick();
        check("s2_req0", 32'(irq_req), 32'h1);
        check("s2_id0", 32'(irq_id), 32'h0);
        ack_once();
        check("s2_pend0", 32'(pending), 32'h00);

        // Masked source retained, ack in IDLE ignored, unmask releases it
        irq_mask = 8'h80;
        pulse(8'h88);
        check("s3_pend", 32'(pending), 32'h88);
        tick();
        check("s3_id3", 32'(irq_id), 32'h3);
        irq_mask = 8'h00;
        irq_mask = 8'h80;
        ack_once();
        check("s3_pend80", 32'(pending), 32'h80);
        check("s3_req_off", 32'(irq_req), 32'h0);
        ack_once();
        check("s3_idle_ack", 32'(pending), 32'h80);
        check("s3_still_off", 32'(irq_req), 32'h0);
        irq_mask = 8'h00;
        tick();
        check("s3_req7", 32'(irq_req), 32'h1);
        check("s3_id7", 32'(irq_id), 32'h7);
        ack_once();
        check("s3_pend0", 32'(pending), 32'h00);

        // Offered id stable against masking and new edges; set beats clear
        pulse(8'h04);
        tick();
        check("s4_id2", 32'(irq_id), 32'h2);
        irq_mask = 8'h04;
        pulse(8'h10);
        check("s4_hold_id", 32'(irq_id), 32'h2);
        check("s4_accum", 32'(pending), 32'h14);
        irq_mask = 8'h00;
        irq_in = 8'h04;
        repeat (SYNC) tick();
        ack_once();
        irq_in = 8'h00;
        check("s4_setwin", 32'(pending), 32'h14);
        check("s4_gap", 32'(irq_req), 32'h0);
        tick();
        check("s4_id4", 32'(irq_id), 32'h4);
        ack_once();
        tick();
        check("s4_reoffer", 32'(irq_id), 32'h2);
        check("s4_reoffer_req", 32'(irq_req), 32'h1);
        ack_once();
        repeat (SYNC) tick();
        check("s4_pend0", 32'(pending), 32'h00);

        // Level high across reset release: exactly one offer
        rst_n  = 1'b0;
        irq_in = 8'h20;
        tick();
        rst_n = 1'b1;
        repeat (1 + SYNC) tick();
        check("s5_pend", 32'(pending), 32'h20);
        tick();
        check("s5_id5", 32'(irq_id), 32'h5);
        ack_once();
        repeat (3) tick();
        check("s5_no_reoffer", 32'(irq_req), 32'h0);
        check("s5_pend0", 32'(pending), 32'h00);
        irq_in = 8'h00;
        repeat (SYNC + 1) tick();

        // Asynchronous reset mid-offer
        pulse(8'h06);
        tick();
        check("s6_req", 32'(irq_req), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("s6_async_req", 32'(irq_req), 32'h0);
        check("s6_async_pend", 32'(pending), 32'h00);
        check("s6_async_id", 32'(irq_id), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule : tb_irq_priority_ctrl

// File: doc/irq_priority_ctrl.md
Name: irq_priority_ctrl

Overview:
- Interrupt front-end for 8 request lines.
- Captures rising edges into a pending register and applies a per-source mask.
- Selects the highest-index unmasked pending source through an 8:3 priority encode.
- Presents the selected ID to the consumer with a req/ack handshake and clears the serviced source on ack.

Parameters:
- N_SRC, 8, number of request sources (block is verified at 8 only).
- ID_W, 3, width of the source ID; must equal clog2(N_SRC).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- irq_in  input  N_SRC  raw request lines; a rising edge on bit i marks source i pending.
- irq_mask  input  N_SRC  1 = source blocked from selection; its pending bit is still retained.
- irq_req  output  1  an ID is being offered.
- irq_id  output  ID_W  offered source index; valid only while irq_req=1.
- irq_ack  input  1  consumer accepts the offered ID.
- pending  output  N_SRC  current pending register, for status readback.

Behaviour:
- Reset (async assert, sync-timed deassert by system): state=IDLE, irq_req=0, irq_id=0, pending=0, edge-history register=0.
- Consequence of the zeroed edge history: a line already high at reset release is captured as an edge on the first clock.
- Edge capture: at each posedge, pending[i] is set if irq_in[i]=1 and hist[i]=0; hist is then updated to irq_in.
- Levels held high set pending only once.
- Selection: sel = pending & ~irq_mask. Priority is highest index first (bit 7 beats bit 0). any_sel = |sel.
- FSM, two states:
  - IDLE: irq_req=0. If any_sel at a posedge, latch irq_id = encode(sel), set irq_req=1, go to OFFER.
  - OFFER: irq_req=1 and irq_id held stable regardless of later pending or mask changes. On a posedge with irq_ack=1: clear pending[irq_id], set irq_req=0, go to IDLE.
- Latency: a rising edge of irq_in sampled at posedge E0 sets pending after E0; irq_req/irq_id become visible after E1 (2 clocks).
- After an ack there is always at least one cycle with irq_req=0 before the next offer.
- irq_ack while in IDLE is ignored.
- Simultaneous clear and new edge on the same bit in one cycle: set wins, so pending stays 1 and the event is not lost.
- New edges on other bits during OFFER accumulate in pending; they do not alter irq_id.
- Masking a source that is being offered has no effect until after its ack.
- Masked pending bits persist and become selectable as soon as they are unmasked.
- A reset asserted mid-handshake drops irq_req immediately (async) and clears all pending bits.

Optional Feature:
- Macro: IRQ_SYNC_EN.
- Defined: irq_in passes through a 2-flop synchronizer (reset to 0) before edge capture. Edge-to-irq_req latency becomes 4 clocks, and irq_in may be asynchronous to clk.
- Undefined: no synchronizer. irq_in must be synchronous to clk; latency is 2 clocks.

Decomposition:
- Shared package: state encoding constants (ST_IDLE=1'b0, ST_OFFER=1'b1), N_SRC, ID_W.
- One natural sub-module: prio_enc8, a combinational 8:3 highest-index-wins encoder with a valid output.
  - Instanced once on sel.
  - Its valid output drives any_sel.
  - Input 0 yields id 0 with valid=0.

Test Plan:
- Reset then pulse irq_in=8'h04 for 1 cycle at E0 -> pending=8'h04 after E0; irq_req=1 and irq_id=2 after E1; ack -> pending=0, irq_req=0.
- Raise irq_in=8'h81 in the same cycle, ack twice -> first offer irq_id=7, one idle cycle, second offer irq_id=0, then pending=0.
- irq_mask=8'h80 with irq_in edges on bits 7 and 3 -> irq_id=3 offered; after its ack pending=8'h80 and irq_req stays 0; clear the mask -> irq_id=7 offered 1 clock later.
- During OFFER of id 2, a new edge on bit 2 coincides with the ack cycle -> pending[2] remains 1 and id 2 is re-offered after one idle cycle.
- Hold irq_in[5]=1 across reset release -> one offer of id 5; after ack no further offer while the line stays high.
- Assert rst_n=0 mid-OFFER asynchronously (between clock edges) -> irq_req=0 and pending=0 before the next clock edge. With IRQ_SYNC_EN defined, repeat the first scenario and check the offer appears after E3.
